// File: rtl/automata_frame_pkg.sv
// Shared definitions for the cellular-automaton generation scheduler.
// Holds the scheduler state encoding, Avalon register indices and
// the bit positions of the CTRL and STATUS register fields.
package automata_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_COMPUTE   = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_RATE      = 3'd1;
    localparam logic [2:0] ADDR_GEN_COUNT = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_STEP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DISP_BANK = 1;
    localparam int STAT_SWAP_PEND = 2;
    localparam int STAT_IRQ       = 3;

endpackage

// File: rtl/automata_frame_ctrl_frame_divider.sv
// Purpose: counts vblank pulses and emits a tick when the count reaches RATE (RATE=0 acts as 1).
// Ports: i_en gates counting, i_clr zeroes the count, i_vblank/i_rate in, o_tick combinational out.
// Latency: o_tick is asserted in the same cycle as the qualifying vblank; no backpressure.
module frame_divider #(
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_vblank,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_tick
);

    logic [RATE_W-1:0] r_cnt;
    logic [RATE_W-1:0] w_rate_eff;
    logic [RATE_W:0]   w_cnt_next;

    assign w_rate_eff = (i_rate == '0) ? RATE_W'(1) : i_rate;
    // One extra bit so the +1 can never wrap past the compare value.
    assign w_cnt_next = {1'b0, r_cnt} + (RATE_W+1)'(1);
    // >= rather than == so a RATE lowered below the running count fires on the next vblank.
    assign o_tick     = i_en & i_vblank & (w_cnt_next >= {1'b0, w_rate_eff});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en && i_vblank) begin
            r_cnt <= w_cnt_next[RATE_W-1:0];
        end
    end

endmodule

// File: rtl/automata_frame_ctrl.sv
// Purpose: generation scheduler; owns display/source bank select, starts the engine every RATE frames, swaps banks in vblank.
// Ports: Avalon slave (chipselect/write/read/address/writedata/readdata), vblank_pulse, eng_start/eng_done, src_bank, disp_bank, irq.
// Latency: reads return one cycle after the strobe, writes land next cycle; no wait states, no backpressure.
module automata_frame_ctrl #(
    parameter int GEN_W  = 32,
    parameter int RATE_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        vblank_pulse,
    output logic        eng_start,
    input  logic        eng_done,
    output logic        src_bank,
    output logic        disp_bank,
    output logic        irq
);
    import automata_frame_pkg::*;

    state_t            r_state;
    logic              r_run;
    logic              r_irq_en;
    logic              r_step_req;
    logic [RATE_W-1:0] r_rate;
    logic [GEN_W-1:0]  r_gen_count;
    logic              r_irq_flag;
    logic              r_disp_bank;
    logic              r_src_bank;
    logic              r_eng_start;
    logic [31:0]       r_readdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_div_en;
    logic        w_div_clr;
    logic        w_swap;
    logic        w_step_wr;
    logic        w_gen_wr;
    logic        w_irq_clr;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    assign w_wr      = chipselect & write;
    assign w_rd      = chipselect & read;
    assign w_div_en  = (r_state == ST_WAIT_TICK);
    assign w_div_clr = (r_state == ST_IDLE);
    assign w_swap    = (r_state == ST_SWAP_WAIT) & vblank_pulse;
    // A step only counts when the same write leaves run cleared.
    assign w_step_wr = w_wr & (address == ADDR_CTRL) & writedata[CTRL_STEP] & ~writedata[CTRL_RUN];
    assign w_gen_wr  = w_wr & (address == ADDR_GEN_COUNT);
    assign w_irq_clr = w_wr & (address == ADDR_STATUS) & writedata[STAT_IRQ];
    assign w_unused_wdata = ^writedata[31:RATE_W];

    frame_divider #(
        .RATE_W (RATE_W)
    ) u_frame_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (w_div_en),
        .i_clr    (w_div_clr),
        .i_vblank (vblank_pulse),
        .i_rate   (r_rate),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_CTRL: begin
                w_rdata[CTRL_RUN]    = r_run;
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            ADDR_RATE:      w_rdata = 32'(r_rate);
            ADDR_GEN_COUNT: w_rdata = 32'(r_gen_count);
            ADDR_STATUS: begin
                w_rdata[STAT_BUSY]      = (r_state != ST_IDLE);
                w_rdata[STAT_DISP_BANK] = r_disp_bank;
                w_rdata[STAT_SWAP_PEND] = (r_state == ST_SWAP_WAIT);
                w_rdata[STAT_IRQ]       = r_irq_flag;
            end
            default: w_rdata = '0;
        endcase
    end

    // Host-owned configuration and read data register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_run      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_rate     <= RATE_W'(1);
            r_readdata <= '0;
        end else begin
            if (w_wr && (address == ADDR_CTRL)) begin
                r_run    <= writedata[CTRL_RUN];
                r_irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (w_wr && (address == ADDR_RATE)) begin
                r_rate <= writedata[RATE_W-1:0];
            end
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // Scheduler FSM plus every register it shares with the host.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_step_req  <= 1'b0;
            r_gen_count <= '0;
            r_irq_flag  <= 1'b0;
            r_disp_bank <= 1'b0;
            r_src_bank  <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;

            // Later assignments win: a running scheduler discards steps.
            if (w_swap)    r_step_req <= 1'b0;
            if (w_step_wr) r_step_req <= 1'b1;
            if (r_run)     r_step_req <= 1'b0;

            // Host clear beats a same-cycle increment.
            if (w_gen_wr) begin
                r_gen_count <= '0;
            end else if (w_swap) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end

            // A completion event is never lost to a same-cycle host clear.
            if (w_swap) begin
                r_irq_flag <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_flag <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_run || r_step_req) r_state <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (w_tick) begin
                        r_eng_start <= 1'b1;
                        r_src_bank  <= r_disp_bank;
                        r_state     <= ST_COMPUTE;
                    end else if (!r_run && !r_step_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                // A vblank coincident with eng_done is not used for the swap.
                ST_COMPUTE: begin
                    if (eng_done) r_state <= ST_SWAP_WAIT;
                end
                ST_SWAP_WAIT: begin
                    if (vblank_pulse) begin
                        r_disp_bank <= ~r_disp_bank;
                        r_src_bank  <= ~r_src_bank;
                        r_state     <= r_run ? ST_WAIT_TICK : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign readdata  = r_readdata;
    assign eng_start = r_eng_start;
    assign src_bank  = r_src_bank;
    assign disp_bank = r_disp_bank;
    assign irq       = r_irq_flag & r_irq_en;

endmodule

// File: tb/tb_automata_frame_ctrl.sv
// Purpose: self-checking bench for automata_frame_ctrl; register table plus scheduling sequences.
// Ports: none; drives the DUT Avalon bus, vblank and engine handshake directly.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at that point.
module tb_automata_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        vblank_pulse;
    logic        eng_start;
    logic        eng_done;
    logic        src_bank;
    logic        disp_bank;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic es_prev = 1'b0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    automata_frame_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .vblank_pulse (vblank_pulse),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .src_bank     (src_bank),
        .disp_bank    (disp_bank),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // eng_start must never be high for two consecutive cycles.
    always @(negedge clk) begin
        if (eng_start) begin
            n_checks++;
            if (es_prev) begin
                n_fail++;
                $display("FAIL eng_start_width actual=2+ cycles required=1 cycle at %0t", $time);
            end
        end
        es_prev = eng_start;
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step_clk();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        chipselect = 1'b1; read = 1'b1; address = a;
        step_clk();
        chipselect = 1'b0; read = 1'b0;
        check(nm_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic vblank();
        vblank_pulse = 1'b1;
        step_clk();
        vblank_pulse = 1'b0;
    endtask

    task automatic done_pulse();
        eng_done = 1'b1;
        step_clk();
        eng_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; vblank_pulse = 1'b0; eng_done = 1'b0;
        repeat (3) step_clk();
        reset_n = 1'b1;
        step_clk();

        check("rst_readdata", readdata, 32'h0);
        check("rst_eng_start", {31'h0, eng_start}, 32'h0);
        check("rst_disp_bank", {31'h0, disp_bank}, 32'h0);
        check("rst_src_bank", {31'h0, src_bank}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // Register table: optional write, then read-back against expected value.
        vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h1};
        vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 3'd7, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 3'd1, 32'h105,      32'h5};
        vecs[6]  = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b1, 3'd0, 32'h4,        32'h4};
        vecs[8]  = '{1'b1, 3'd0, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 3'd2, 32'h1234,     32'h0};
        vecs[10] = '{1'b1, 3'd3, 32'h8,        32'h0};
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            rd_check(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Free-running at RATE=3 with a slow engine.
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'h1);
        step_clk();
        vblank(); check("r3_vb1_no_start", {31'h0, eng_start}, 32'h0);
        vblank(); check("r3_vb2_no_start", {31'h0, eng_start}, 32'h0);
        vblank(); check("r3_vb3_start", {31'h0, eng_start}, 32'h1);
        check("r3_src_eq_disp", {31'h0, src_bank}, 32'h0);
        step_clk(); check("r3_start_one_cycle", {31'h0, eng_start}, 32'h0);
        rd_check(3'd3, 32'h1, "r3_status_compute");
        repeat (46) step_clk();
        done_pulse();
        check("r3_no_swap_before_vb", {31'h0, disp_bank}, 32'h0);
        rd_check(3'd3, 32'h5, "r3_status_swap_pend");
        vblank();
        check("r3_disp_after_swap", {31'h0, disp_bank}, 32'h1);
        check("r3_src_after_swap", {31'h0, src_bank}, 32'h1);
        rd_check(3'd2, 32'h1, "r3_gen_count");
        rd_check(3'd3, 32'hB, "r3_status_after_swap");
        vblank(); check("r3_post_vb1", {31'h0, eng_start}, 32'h0);
        vblank(); check("r3_post_vb2", {31'h0, eng_start}, 32'h0);
        vblank(); check("r3_post_vb3_start", {31'h0, eng_start}, 32'h1);

        // Run cleared mid-COMPUTE: generation and swap still complete, then idle.
        bus_write(3'd0, 32'h0);
        rd_check(3'd3, 32'hB, "stop_status_compute");
        done_pulse();
        vblank();
        check("stop_disp", {31'h0, disp_bank}, 32'h0);
        rd_check(3'd2, 32'h2, "stop_gen_count");
        rd_check(3'd3, 32'h8, "stop_status_idle");
        for (int i = 0; i < 3; i++) begin
            vblank();
            check($sformatf("stop_idle_vb%0d", i), {31'h0, eng_start}, 32'h0);
        end

        // Host clears.
        bus_write(3'd2, 32'h0);
        bus_write(3'd3, 32'h8);
        rd_check(3'd3, 32'h0, "clr_status");
        rd_check(3'd2, 32'h0, "clr_gen");

        // Single step, with eng_done coincident with vblank.
        bus_write(3'd1, 32'd1);
        bus_write(3'd0, 32'h2);
        step_clk();
        rd_check(3'd0, 32'h0, "step_ctrl_readback");
        rd_check(3'd3, 32'h1, "step_status_wait");
        vblank(); check("step_start", {31'h0, eng_start}, 32'h1);
        eng_done = 1'b1; vblank_pulse = 1'b1;
        step_clk();
        eng_done = 1'b0; vblank_pulse = 1'b0;
        check("coinc_no_swap", {31'h0, disp_bank}, 32'h0);
        rd_check(3'd3, 32'h5, "coinc_status");
        vblank();
        check("coinc_swap_next_vb", {31'h0, disp_bank}, 32'h1);
        rd_check(3'd2, 32'h1, "step_gen_count");
        rd_check(3'd3, 32'hA, "step_status_idle");
        vblank(); check("step_no_second_start", {31'h0, eng_start}, 32'h0);
        rd_check(3'd3, 32'hA, "step_still_idle");

        // irq, RATE=0 clamp, GEN_COUNT write colliding with the swap.
        bus_write(3'd3, 32'h8);
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'h6);
        check("irq_low_before", {31'h0, irq}, 32'h0);
        step_clk();
        vblank(); check("rate0_start_first_vb", {31'h0, eng_start}, 32'h1);
        done_pulse();
        check("irq_low_compute", {31'h0, irq}, 32'h0);
        chipselect = 1'b1; write = 1'b1; address = 3'd2; writedata = 32'h55;
        vblank_pulse = 1'b1;
        step_clk();
        chipselect = 1'b0; write = 1'b0; vblank_pulse = 1'b0;
        check("irq_rise_with_swap", {31'h0, irq}, 32'h1);
        check("irq_swap_disp", {31'h0, disp_bank}, 32'h0);
        rd_check(3'd2, 32'h0, "gen_write_wins");
        bus_write(3'd3, 32'h8);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Reset in the middle of COMPUTE.
        bus_write(3'd1, 32'd1);
        bus_write(3'd0, 32'h5);
        step_clk();
        vblank(); check("pre_rst_start1", {31'h0, eng_start}, 32'h1);
        done_pulse();
        vblank();
        vblank(); check("pre_rst_start2", {31'h0, eng_start}, 32'h1);
        check("pre_rst_disp", {31'h0, disp_bank}, 32'h1);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd_check(3'd3, 32'hB, "pre_rst_status");
        reset_n = 1'b0; vblank_pulse = 1'b1;
        step_clk();
        vblank_pulse = 1'b0;
        check("mid_rst_eng_start", {31'h0, eng_start}, 32'h0);
        check("mid_rst_disp", {31'h0, disp_bank}, 32'h0);
        check("mid_rst_src", {31'h0, src_bank}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        step_clk();
        rd_check(3'd0, 32'h0, "post_rst_ctrl");
        rd_check(3'd1, 32'h1, "post_rst_rate");
        rd_check(3'd2, 32'h0, "post_rst_gen");
        done_pulse();
        rd_check(3'd3, 32'h0, "post_rst_status_done_ignored");
        vblank(); check("post_rst_no_start", {31'h0, eng_start}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/automata_frame_ctrl.md
# automata_frame_ctrl

Generation scheduler for the cellular-automaton display path. Owns the double-buffered pattern memory: selects which bank the VGA emulator scans out and which bank the update engine reads, starts one engine generation every RATE frames, and swaps banks only during vertical blank so no frame is torn. Sits between the Avalon host bus, the VGA timing generator (vblank pulse), and the generation engine.

## Interface

- GEN_W, 32, generation counter width
- RATE_W, 8, frames-per-generation register width
- clk  in  1  system clock; the single clock for this block
- reset_n  in  1  reset, synchronous, active-low
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  32  write data
- readdata  out  32  registered read data
- vblank_pulse  in  1  one-cycle pulse at start of vertical blank
- eng_start  out  1  one-cycle pulse; begin one generation
- eng_done  in  1  one-cycle pulse; generation written to destination bank
- src_bank  out  1  bank the engine reads; destination is ~src_bank
- disp_bank  out  1  bank the VGA emulator scans out
- irq  out  1  generation-complete interrupt, level

## Operation

- Registers:
  - 0 CTRL: bit0 run, bit1 step (write-only, self-clearing), bit2 irq_en
  - 1 RATE: vblanks per generation; 0 treated as 1
  - 2 GEN_COUNT: read-only count; any write clears it to 0
  - 3 STATUS: bit0 busy (state≠IDLE), bit1 disp_bank, bit2 swap_pending, bit3 irq_flag; write 1 to bit3 clears it
  - Other addresses read 0; writes to them are ignored.
- FSM states:
  - IDLE: enter WAIT_TICK if run=1 or step_req=1. step_req is set by a step write while run=0. step_req is discarded if run=1.
  - WAIT_TICK: frame_cnt increments on each vblank_pulse. When frame_cnt+1 ≥ max(RATE,1), pulse eng_start, set src_bank=disp_bank, clear frame_cnt, and go to COMPUTE.
  - COMPUTE: wait for eng_done, then go to SWAP_WAIT (swap_pending=1).
  - SWAP_WAIT: on vblank_pulse, toggle disp_bank and src_bank, increment GEN_COUNT (wraps mod 2^GEN_W), and set irq_flag. Then go to WAIT_TICK if run=1, else IDLE. Clear step_req.
- Clearing run during WAIT_TICK returns the FSM to IDLE. Clearing run during COMPUTE or SWAP_WAIT completes the current generation and swap, then goes to IDLE. A generation is never aborted.
- eng_done outside COMPUTE is ignored.
- irq = irq_flag & irq_en.
- If a host write to GEN_COUNT and an increment occur in the same cycle, the host write wins and GEN_COUNT=0.
- A RATE write takes effect on the next comparison; frame_cnt is not reset.

## Timing

- Reset values: readdata=0, eng_start=0, src_bank=0, disp_bank=0, irq=0, run=0, irq_en=0, RATE=1, GEN_COUNT=0, state=IDLE.
- Reads: readdata is valid the cycle after chipselect&read. There are no wait states.
- Writes take effect the cycle after chipselect&write.
- eng_start is high for exactly one cycle, the cycle after the qualifying vblank_pulse.
- src_bank is stable from eng_start until the swap.
- eng_done and vblank_pulse in the same cycle while in COMPUTE: the swap waits for the next vblank. The same pulse never serves as both completion and swap.
- disp_bank, src_bank, GEN_COUNT and irq_flag all update the cycle after the swap vblank_pulse.
- Reset asserted mid-operation: all state returns to reset values the next cycle, and eng_start stays low.

## Structure

- Package automata_frame_pkg holds:
  - state enum (IDLE, WAIT_TICK, COMPUTE, SWAP_WAIT)
  - register address localparams
  - CTRL/STATUS bit-position constants
- One sub-module is natural: frame_divider. It contains the vblank counter with RATE compare and the zero→1 clamp, and outputs a one-cycle tick.
- Register file and FSM stay in the top module.

## Test plan

- Reset, then read all registers: CTRL=0, RATE=1, GEN_COUNT=0, STATUS=0; disp_bank=0.
- RATE=3, run=1, engine answers eng_done 50 cycles after eng_start:
  - eng_start fires the cycle after the 3rd vblank.
  - The swap occurs on the 4th vblank.
  - GEN_COUNT=1, disp_bank=1.
  - The next eng_start comes 3 vblanks after the swap.
- Step with run=0: exactly one generation runs, GEN_COUNT 0→1, state returns to IDLE. A second vblank produces no eng_start.
- eng_done coincident with vblank_pulse: no swap that cycle; the swap occurs on the following vblank.
- irq_en=1: irq rises with the swap. Writing STATUS=0x8 drops irq the next cycle. Writing GEN_COUNT in the swap cycle leaves 0.
- run cleared in COMPUTE: the swap still completes, GEN_COUNT increments once, then IDLE. Reset mid-COMPUTE returns all outputs to reset values.
